wbu: RTL and testbench

Write-back unit of the single-cycle-issue NPC core, directly downstream of the execute unit. Accepts one completed instruction per cycle from EXU over a valid/ready handshake and holds it for one cycle in a write-back register. It then commits the result into the 32×32 general register file. Also provides the two decode-side register read ports with bypass, a retired-instruction counter, and the `ebreak` halt state used to end simulation.

---
 rtl/npc_pkg.sv | 14 +
 rtl/wbu_regfile.sv | 38 +++
 rtl/wbu.sv | 127 ++++++++++++
 tb/tb_wbu.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared constants and types for the NPC core back end.
package npc_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;
  localparam int REG_A0 = 10;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wbu_regfile.sv
// 32x32 general register file: two combinational read ports, one synchronous
// write port, x0 hardwired to zero, and a tap on a0 for halt-code capture.
module regfile
  import npc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2,
  output logic [XLEN-1:0]   a0_data
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wen && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // x0 is never written, but the read mux still forces zero so the
  // guarantee does not depend on the write guard alone.
  always_comb begin
    rdata1  = (raddr1 == '0) ? '0 : regs[raddr1];
    rdata2  = (raddr2 == '0) ? '0 : regs[raddr2];
    a0_data = regs[REG_A0];
  end

endmodule

// File: rtl/wbu.sv
// Write-back unit: one-entry write-back buffer, register file commit with read
// bypass, retired-instruction counter and the ebreak halt state machine.
module wbu
  import npc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wen,
  input  logic [XLEN-1:0]   in_data,
  input  logic              in_ebreak,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic              commit_valid,
  output logic [XLEN-1:0]   commit_pc,
  output logic [63:0]       retire_cnt,
  output logic              halted,
  output logic [XLEN-1:0]   halt_pc,
  output logic [XLEN-1:0]   halt_code
);

  wb_state_t         state;
  logic              wb_valid;
  logic [XLEN-1:0]   wb_pc;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_wen;
  logic [XLEN-1:0]   wb_data;
  logic              wb_ebreak;

  logic              accept;
  logic              retire;
  logic              rf_wen;
  logic [XLEN-1:0]   rf_rdata1;
  logic [XLEN-1:0]   rf_rdata2;
  logic [XLEN-1:0]   rf_a0;

  // Stop accepting as soon as an ebreak sits in the buffer so nothing
  // younger can slip past it.
  assign in_ready = (state == RUN) && !(wb_valid && wb_ebreak);
  assign accept   = in_valid && in_ready;
  assign retire   = wb_valid && (state == RUN);
  assign rf_wen   = retire && wb_wen;

  assign commit_valid = retire;
  assign commit_pc    = wb_pc;
  assign halted       = (state == HALT);

  regfile u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .wen    (rf_wen),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2),
    .a0_data(rf_a0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid  <= 1'b0;
      wb_pc     <= '0;
      wb_rd     <= '0;
      wb_wen    <= 1'b0;
      wb_data   <= '0;
      wb_ebreak <= 1'b0;
    end else begin
      wb_valid <= accept;
      if (accept) begin
        wb_pc     <= in_pc;
        wb_rd     <= in_rd;
        wb_wen    <= in_wen;
        wb_data   <= in_data;
        wb_ebreak <= in_ebreak;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (retire) begin
      retire_cnt <= retire_cnt + 64'd1;
    end
  end

  // a0 is read from the register file itself: an ebreak never writes rd,
  // so the stored value is already architecturally current.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      halt_pc   <= '0;
      halt_code <= '0;
    end else begin
      case (state)
        RUN: begin
          if (retire && wb_ebreak) begin
            state     <= HALT;
            halt_pc   <= wb_pc;
            halt_code <= rf_a0;
          end
        end
        HALT: state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    rs1_data = rf_rdata1;
    rs2_data = rf_rdata2;
    if (wb_valid && wb_wen && (wb_rd == rs1_addr) && (rs1_addr != '0)) begin
      rs1_data = wb_data;
    end
    if (wb_valid && wb_wen && (wb_rd == rs2_addr) && (rs2_addr != '0)) begin
      rs2_data = wb_data;
    end
  end

endmodule

// File: tb/tb_wbu.sv
// Scoreboard bench for wbu: a driver models architectural register state and
// queues expected commits; a negedge monitor checks commits, counter and halt.
module tb_wbu;
  import npc_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc = '0;
  logic [REG_AW-1:0] in_rd = '0;
  logic              in_wen = 1'b0;
  logic [XLEN-1:0]   in_data = '0;
  logic              in_ebreak = 1'b0;
  logic [REG_AW-1:0] rs1_addr = '0;
  logic [REG_AW-1:0] rs2_addr = '0;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic              commit_valid;
  logic [XLEN-1:0]   commit_pc;
  logic [63:0]       retire_cnt;
  logic              halted;
  logic [XLEN-1:0]   halt_pc;
  logic [XLEN-1:0]   halt_code;

  wbu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_rd       (in_rd),
    .in_wen      (in_wen),
    .in_data     (in_data),
    .in_ebreak   (in_ebreak),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .commit_valid(commit_valid),
    .commit_pc   (commit_pc),
    .retire_cnt  (retire_cnt),
    .halted      (halted),
    .halt_pc     (halt_pc),
    .halt_code   (halt_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        ebreak;
    logic [31:0] hcode;
    int          exp_cyc;
  } entry_t;

  entry_t      sb[$];
  entry_t      mon_e;
  logic [31:0] model_rf [32];
  logic        blocked = 1'b0;
  logic [63:0] exp_cnt = '0;
  logic        exp_halt = 1'b0;
  logic [31:0] exp_hpc = '0;
  logic [31:0] exp_hcode = '0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] pc_ctr = 32'h8000_0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare this cycle's registered state, then absorb the commit
  // so its effect is expected from the next cycle on.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("retire_cnt", retire_cnt, exp_cnt);
      checkOutput("halted", {63'd0, halted}, {63'd0, exp_halt});
      if (exp_halt) begin
        checkOutput("halt_pc", {32'd0, halt_pc}, {32'd0, exp_hpc});
        checkOutput("halt_code", {32'd0, halt_code}, {32'd0, exp_hcode});
      end
      if (commit_valid) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_commit", {63'd0, commit_valid}, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("commit_pc", {32'd0, commit_pc}, {32'd0, mon_e.pc});
          checkOutput("commit_latency", 64'(cyc), 64'(mon_e.exp_cyc));
          exp_cnt = exp_cnt + 64'd1;
          if (mon_e.ebreak) begin
            exp_halt  = 1'b1;
            exp_hpc   = mon_e.pc;
            exp_hcode = mon_e.hcode;
          end
        end
      end else if (sb.size() > 0 && sb[0].exp_cyc <= cyc) begin
        checkOutput("commit_valid", {63'd0, commit_valid}, 64'd1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic wen,
                               input logic [31:0] data, input logic eb,
                               input logic [4:0] a1, input logic [4:0] a2);
    logic acc;
    int   c;
    entry_t e;
    @(negedge clk);
    in_valid  = v;
    in_pc     = pc_ctr;
    in_rd     = rd;
    in_wen    = wen;
    in_data   = data;
    in_ebreak = eb;
    rs1_addr  = a1;
    rs2_addr  = a2;
    #1;
    checkOutput("in_ready", {63'd0, in_ready}, {63'd0, !blocked});
    checkOutput("rs1_data", {32'd0, rs1_data}, {32'd0, model_rf[a1]});
    checkOutput("rs2_data", {32'd0, rs2_data}, {32'd0, model_rf[a2]});
    acc = v && !blocked;
    c   = cyc;
    @(posedge clk);
    if (acc) begin
      e.pc      = pc_ctr;
      e.ebreak  = eb;
      e.hcode   = model_rf[REG_A0];
      e.exp_cyc = c + 1;
      sb.push_back(e);
      if (wen && rd != 5'd0) model_rf[rd] = data;
      if (eb) blocked = 1'b1;
      pc_ctr = pc_ctr + 32'd4;
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    blocked  = 1'b0;
    exp_cnt  = '0;
    exp_halt = 1'b0;
    #1;
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("rst_commit_valid", {63'd0, commit_valid}, 64'd0);
    checkOutput("rst_commit_pc", {32'd0, commit_pc}, 64'd0);
    checkOutput("rst_retire_cnt", retire_cnt, 64'd0);
    checkOutput("rst_halted", {63'd0, halted}, 64'd0);
    checkOutput("rst_halt_pc", {32'd0, halt_pc}, 64'd0);
    checkOutput("rst_halt_code", {32'd0, halt_code}, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    doReset();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 5'($urandom), 1'b1, $urandom, 1'b0, 5'(i), 5'(31 - i));
    end

    // Single write with bypass then register-file read.
    pc_ctr = 32'h8000_0000;
    applyStimulus(1'b1, 5'd5, 1'b1, 32'h1234_5678, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd5, 5'd5);
    applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd5, 5'd0);

    // Back-to-back stream with a repeated destination.
    applyStimulus(1'b1, 5'd1, 1'b1, 32'd10, 1'b0, 5'd1, 5'd2);
    applyStimulus(1'b1, 5'd2, 1'b1, 32'd20, 1'b0, 5'd1, 5'd2);
    applyStimulus(1'b1, 5'd3, 1'b1, 32'd30, 1'b0, 5'd2, 5'd3);
    applyStimulus(1'b1, 5'd1, 1'b1, 32'd40, 1'b0, 5'd3, 5'd1);
    applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd1, 5'd2);
    applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd3, 5'd1);

    // x0 write is dropped but still retires.
    applyStimulus(1'b1, 5'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd0, 5'd1);

    // Random traffic, biased toward low registers to exercise bypass.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 3) != 0, rd, 1'($urandom), $urandom, 1'b0,
                    ($urandom_range(0, 1) == 0) ? rd : 5'($urandom_range(0, 7)),
                    5'($urandom));
    end

    // Halt with a0 = 0, then attempts that must be refused.
    applyStimulus(1'b1, 5'd10, 1'b1, 32'd0, 1'b0, 5'd10, 5'd0);
    pc_ctr = 32'h8000_0010;
    applyStimulus(1'b1, 5'd0, 1'b0, 32'd0, 1'b1, 5'd10, 5'd0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 5'd4, 1'b1, $urandom, 1'b0, 5'd4, 5'd10);
    end

    // Halt immediately behind an a0 write: the code must reflect that write.
    doReset();
    applyStimulus(1'b1, 5'd10, 1'b1, 32'h0000_CAFE, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd0, 1'b0, 32'd0, 1'b1, 5'd10, 5'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'd6, 1'b1, $urandom, 1'b0, 5'd10, 5'd6);
    end

    // Reset while an entry for x7 is buffered: it must vanish.
    doReset();
    applyStimulus(1'b1, 5'd7, 1'b1, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0);
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd7, 5'd7);
    end
    applyStimulus(1'b1, 5'd7, 1'b1, 32'h0000_0077, 1'b0, 5'd7, 5'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd7, 5'd0);
    end

    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
